// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC checker and its companions.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } crc_state_e;

    // Bit n set means a CRC width of n bits is supported.
    localparam logic [32:0] CRC_W_ALLOWED = 33'h1_0001_0100;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Reverses the low w bits of v; the result is right-aligned.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of MSB-first CRC division: eight unrolled shift/XOR steps.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h07)
) (
    input  logic [CRC_W-1:0] crc,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_next
);

    logic [CRC_W-1:0] acc;

    // NOTE: acc is a combinational temporary rebuilt on every evaluation, so
    // blocking assignments are required for each unrolled step to see the last.
    always_comb begin
        acc = crc ^ (CRC_W'(data) << (CRC_W - 8));
        for (int i = 0; i < 8; i++) begin
            acc = acc[CRC_W-1] ? ((acc << 1) ^ POLY) : (acc << 1);
        end
        crc_next = acc;
    end

endmodule

// File: rtl/crc_stream_checker.sv
// Streaming CRC checker: delays the byte stream by the CRC length so only the
// payload reaches the engine, then compares against the trailing CRC bytes.
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    input  logic             data_last,
    output logic             crc_done,
    output logic             crc_error,
    output logic             short_frame,
    output logic [CRC_W-1:0] crc_calc
);

    localparam int NB = CRC_W / 8;
    localparam int CW = $clog2(NB + 1);

    if (CRC_W > 32 || !CRC_W_ALLOWED[CRC_W]) begin : g_bad_width
        $error("crc_stream_checker: CRC_W must be 8, 16 or 32");
    end

    crc_state_e       state_q, state_d;
    logic [7:0]       dly_q [NB];
    logic [CW-1:0]    cnt_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_step;
    logic [CRC_W-1:0] crc_fed;
    logic [CRC_W-1:0] fed_rev;
    logic [CRC_W-1:0] crc_final;
    logic [CRC_W-1:0] rx_crc;
    logic [7:0]       engine_byte;
    logic [7:0]       wire_bytes [NB];
    logic             last_beat;
    logic             evict;
    logic             short_now;

    assign last_beat = data_valid & data_last;
    // Once the line is full every further beat, including the last, pushes
    // the oldest byte into the engine.
    assign evict     = data_valid && (cnt_q == CW'(NB));
    assign short_now = (cnt_q != CW'(NB));

    assign engine_byte = REFLECT ? bitrev8(dly_q[NB-1]) : dly_q[NB-1];

    crc_byte_step #(
        .CRC_W(CRC_W),
        .POLY (POLY)
    ) u_step (
        .crc     (crc_q),
        .data    (engine_byte),
        .crc_next(crc_step)
    );

    assign crc_fed   = evict ? crc_step : crc_q;
    assign fed_rev   = CRC_W'(bitrev(32'(crc_fed), CRC_W));
    assign crc_final = (REFLECT ? fed_rev : crc_fed) ^ XOR_OUT;

    // NOTE: every combinational output gets a default before any conditional
    // or loop assignment, so no path can leave a latch behind.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            wire_bytes[k] = '0;
        end
        wire_bytes[NB-1] = data_in;
        for (int k = 0; k < NB - 1; k++) begin
            wire_bytes[k] = dly_q[NB-2-k];
        end
        rx_crc = '0;
        for (int k = 0; k < NB; k++) begin
            if (REFLECT) rx_crc[k*8 +: 8]        = wire_bytes[k];
            else         rx_crc[(NB-1-k)*8 +: 8] = wire_bytes[k];
        end
    end

    always_comb begin
        state_d = state_q;
        if (data_valid) begin
            if (data_last) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_d = FILL;
                    FILL:    if (evict) state_d = RUN;
                    RUN:     state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
    // explicitly to give a known, zeroed buffer after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                dly_q[i] <= '0;
            end
            cnt_q       <= '0;
            crc_q       <= INIT;
            crc_done    <= 1'b0;
            crc_error   <= 1'b0;
            short_frame <= 1'b0;
            crc_calc    <= '0;
        end else begin
            crc_done <= last_beat;
            if (last_beat) begin
                for (int i = 0; i < NB; i++) begin
                    dly_q[i] <= '0;
                end
                cnt_q       <= '0;
                crc_q       <= INIT;
                crc_error   <= (crc_final != rx_crc) | short_now;
                short_frame <= short_now;
                crc_calc    <= crc_final;
            end else if (data_valid) begin
                dly_q[0] <= data_in;
                for (int i = 1; i < NB; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
                if (cnt_q != CW'(NB)) cnt_q <= cnt_q + CW'(1);
                if (evict)            crc_q <= crc_step;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_checker.sv
// Randomised self-checking bench for crc_stream_checker with CRC-8/16/32 instances.
module tb_crc_stream_checker;

    typedef logic [7:0] bq_t [$];

    localparam int          W_TAB    [3] = '{8, 16, 32};
    localparam logic [31:0] POLY_TAB [3] = '{32'h07, 32'h1021, 32'h04C11DB7};
    localparam logic [31:0] INIT_TAB [3] = '{32'h00, 32'hFFFF, 32'hFFFFFFFF};
    localparam logic [31:0] XOR_TAB  [3] = '{32'h00, 32'h0000, 32'hFFFFFFFF};
    localparam bit          REFL_TAB [3] = '{1'b0, 1'b0, 1'b1};

    logic        clk;
    logic        rst;
    logic        valid_i [3];
    logic [7:0]  data_i  [3];
    logic        last_i  [3];
    logic        done_o  [3];
    logic        err_o   [3];
    logic        short_o [3];
    logic [31:0] calc_o  [3];
    logic [7:0]  calc8;
    logic [15:0] calc16;
    logic [31:0] calc32;

    int n_checks = 0;
    int n_fail   = 0;

    assign calc_o[0] = 32'(calc8);
    assign calc_o[1] = 32'(calc16);
    assign calc_o[2] = calc32;

    crc_stream_checker #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .REFLECT(1'b0)) u_crc8 (
        .clk(clk), .reset(rst), .data_valid(valid_i[0]), .data_in(data_i[0]), .data_last(last_i[0]),
        .crc_done(done_o[0]), .crc_error(err_o[0]), .short_frame(short_o[0]), .crc_calc(calc8)
    );

    crc_stream_checker #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .REFLECT(1'b0)) u_crc16 (
        .clk(clk), .reset(rst), .data_valid(valid_i[1]), .data_in(data_i[1]), .data_last(last_i[1]),
        .crc_done(done_o[1]), .crc_error(err_o[1]), .short_frame(short_o[1]), .crc_calc(calc16)
    );

    crc_stream_checker #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b1)) u_crc32 (
        .clk(clk), .reset(rst), .data_valid(valid_i[2]), .data_in(data_i[2]), .data_last(last_i[2]),
        .crc_done(done_o[2]), .crc_error(err_o[2]), .short_frame(short_o[2]), .crc_calc(calc32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev_w(input logic [31:0] v, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Textbook CRC over the first plen bytes of q: bit-serial division for the
    // normal form, right-shifting register with mirrored polynomial when reflected.
    function automatic logic [31:0] model_crc(input int sel, input bq_t q, input int plen);
        int          w    = W_TAB[sel];
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [31:0] r;
        logic [31:0] rp;
        logic [7:0]  b;
        logic        fb;
        if (REFL_TAB[sel]) begin
            rp = rev_w(POLY_TAB[sel], w);
            r  = rev_w(INIT_TAB[sel], w);
            for (int j = 0; j < plen; j++) begin
                r = r ^ 32'(q[j]);
                for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
            end
        end else begin
            r = INIT_TAB[sel];
            for (int j = 0; j < plen; j++) begin
                b = q[j];
                for (int i = 7; i >= 0; i--) begin
                    fb = b[i] ^ r[w-1];
                    r  = (r << 1) & mask[31:0];
                    if (fb) r = r ^ POLY_TAB[sel];
                end
            end
        end
        return r ^ XOR_TAB[sel];
    endfunction

    function automatic bq_t str_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Appends the CRC of the payload in the wire order of instance sel.
    function automatic bq_t with_crc(input int sel, input bq_t payload);
        bq_t         q  = payload;
        int          nb = W_TAB[sel] / 8;
        logic [31:0] c  = model_crc(sel, payload, payload.size());
        for (int k = 0; k < nb; k++) begin
            if (REFL_TAB[sel]) q.push_back(c[8*k +: 8]);
            else               q.push_back(c[8*(nb-1-k) +: 8]);
        end
        return q;
    endfunction

    task automatic send_frame(input int sel, input bq_t q, input int max_gap, input string tag);
        int          n  = q.size();
        int          nb = W_TAB[sel] / 8;
        bit          is_short;
        logic [31:0] exp_calc;
        logic [31:0] rx;
        logic        exp_err;
        for (int i = 0; i < n; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                valid_i[sel] = 1'b0;
                @(negedge clk);
                check({tag, " done_in_gap"}, 32'(done_o[sel]), 32'd0);
            end
            valid_i[sel] = 1'b1;
            data_i[sel]  = q[i];
            last_i[sel]  = (i == n - 1);
            @(negedge clk);
            if (i != n - 1) check({tag, " done_mid_frame"}, 32'(done_o[sel]), 32'd0);
        end
        valid_i[sel] = 1'b0;
        last_i[sel]  = 1'b0;
        is_short = (n <= nb);
        exp_calc = model_crc(sel, q, is_short ? 0 : n - nb);
        rx = '0;
        for (int k = 0; k < nb && k < n; k++) begin
            if (REFL_TAB[sel]) rx = rx | (32'(q[n-nb+k]) << (8 * k));
            else               rx = (rx << 8) | 32'(q[n-nb+k]);
        end
        exp_err = is_short || (exp_calc != rx);
        check({tag, " done"},  32'(done_o[sel]),  32'd1);
        check({tag, " short"}, 32'(short_o[sel]), 32'(is_short));
        check({tag, " error"}, 32'(err_o[sel]),   32'(exp_err));
        check({tag, " calc"},  calc_o[sel],       exp_calc);
    endtask

    initial begin
        bq_t q;
        bq_t p;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            valid_i[s] = 1'b0;
            data_i[s]  = 8'h00;
            last_i[s]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset done%0d", s),  32'(done_o[s]),  32'd0);
            check($sformatf("reset error%0d", s), 32'(err_o[s]),   32'd0);
            check($sformatf("reset short%0d", s), 32'(short_o[s]), 32'd0);
            check($sformatf("reset calc%0d", s),  calc_o[s],       32'd0);
        end

        q = str_q("123456789");
        q.push_back(8'hF4);
        send_frame(0, q, 0, "crc8_std");
        check("crc8_std value", calc_o[0], 32'hF4);
        check("crc8_std ok", 32'(err_o[0]), 32'd0);
        @(negedge clk);
        check("crc8_std pulse_len", 32'(done_o[0]), 32'd0);
        check("crc8_std calc_held", calc_o[0], 32'hF4);

        q = str_q("123456789");
        q.push_back(8'h29);
        q.push_back(8'hB1);
        send_frame(1, q, 0, "crc16_std");
        check("crc16_std value", calc_o[1], 32'h29B1);
        check("crc16_std ok", 32'(err_o[1]), 32'd0);
        q[4] = q[4] ^ 8'h01;
        send_frame(1, q, 0, "crc16_flip");
        check("crc16_flip error", 32'(err_o[1]), 32'd1);

        q = str_q("123456789");
        q.push_back(8'h26);
        q.push_back(8'h39);
        q.push_back(8'hF4);
        q.push_back(8'hCB);
        send_frame(2, q, 3, "crc32_std");
        check("crc32_std value", calc_o[2], 32'hCBF43926);
        check("crc32_std ok", 32'(err_o[2]), 32'd0);

        q = '{8'hAA, 8'h55};
        send_frame(1, q, 0, "short2");
        check("short2 flag", 32'(short_o[1]), 32'd1);
        check("short2 error", 32'(err_o[1]), 32'd1);
        q = '{8'hAA};
        send_frame(1, q, 0, "short1");
        check("short1 flag", 32'(short_o[1]), 32'd1);
        check("short1 error", 32'(err_o[1]), 32'd1);
        q = '{8'h3C};
        send_frame(0, q, 0, "crc8_single");
        check("crc8_single error", 32'(err_o[0]), 32'd1);

        q = str_q("123456789");
        q.push_back(8'hF4);
        send_frame(0, q, 0, "b2b_good");
        check("b2b_good error", 32'(err_o[0]), 32'd0);
        q[9] = 8'hF5;
        send_frame(0, q, 0, "b2b_bad");
        check("b2b_bad error", 32'(err_o[0]), 32'd1);

        for (int i = 0; i < 4; i++) begin
            valid_i[1] = 1'b1;
            data_i[1]  = 8'(8'h31 + i);
            last_i[1]  = 1'b0;
            @(negedge clk);
        end
        valid_i[1] = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid error", 32'(err_o[1]),   32'd0);
        check("rst_mid short", 32'(short_o[1]), 32'd0);
        check("rst_mid calc",  calc_o[1],       32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid done", 32'(done_o[1]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid done_after", 32'(done_o[1]), 32'd0);
        q = str_q("123456789");
        q.push_back(8'h29);
        q.push_back(8'hB1);
        send_frame(1, q, 0, "rst_mid_next");
        check("rst_mid_next ok", 32'(err_o[1]), 32'd0);

        for (int s = 0; s < 3; s++) begin
            for (int f = 0; f < 30; f++) begin
                p = {};
                if ($urandom_range(1, 0) == 1) begin
                    for (int i = 0; i < int'($urandom_range(10, 0)); i++) p.push_back(8'($urandom));
                    q = with_crc(s, p);
                    if ($urandom_range(3, 0) == 0) q[$urandom_range(q.size() - 1, 0)] ^= 8'(1 << $urandom_range(7, 0));
                end else begin
                    for (int i = 0; i < int'($urandom_range(12, 1)); i++) p.push_back(8'($urandom));
                    q = p;
                end
                send_frame(s, q, ($urandom_range(1, 0) == 1) ? 2 : 0, $sformatf("rand%0d_%0d", s, f));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
